// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: issues one aligned doubleword read per load, extracts
// and extends the addressed bytes, and commits one result per instruction.
module mem_wb_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_we,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_alu_res,
    output logic            dmem_req,
    output logic [XLEN-1:0] dmem_addr,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [4:0]      WriteAddr,
    output logic [XLEN-1:0] WriteData,
    output logic            WriteEnable,
    output logic            retire_valid,
    output logic            load_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [4:0]      rd_reg;
    logic            rd_we_reg;
    logic            is_load_reg;
    logic [2:0]      funct3_reg;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] alu_res_reg;
    logic [XLEN-1:0] load_res_reg;
    logic            err_reg;

    logic            accept;
    logic            in_err;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;

    assign accept = in_valid && in_ready;

    // Alignment and legality are judged on the incoming instruction so the
    // accept edge can already choose between MEM and WB.
    always_comb begin
        in_err = 1'b0;
        if (in_is_load) begin
            case (in_funct3)
                3'b001, 3'b101: in_err = in_addr[0];
                3'b010, 3'b110: in_err = |in_addr[1:0];
                3'b011:         in_err = |in_addr[2:0];
                3'b111:         in_err = 1'b1;
                default:        in_err = 1'b0;
            endcase
        end
    end

    always_comb begin
        shifted  = dmem_rdata >> {addr_reg[2:0], 3'b000};
        load_ext = '0;
        case (funct3_reg)
            3'b000:  load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b011:  load_ext = shifted;
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'b110:  load_ext = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: load_ext = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (in_is_load && !in_err) ? MEM : WB;
            MEM:  if (dmem_ack) state_next = WB;
            WB:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = rst && (state_reg == IDLE);
        dmem_req     = (state_reg == MEM);
        dmem_addr    = '0;
        WriteAddr    = '0;
        WriteData    = '0;
        WriteEnable  = 1'b0;
        retire_valid = 1'b0;
        load_err     = 1'b0;
        if (state_reg == MEM) begin
            dmem_addr = {addr_reg[XLEN-1:3], 3'b000};
        end
        if (state_reg == WB) begin
            WriteAddr    = rd_reg;
            WriteData    = is_load_reg ? load_res_reg : alu_res_reg;
            WriteEnable  = rd_we_reg && (rd_reg != 5'd0) && !err_reg;
            retire_valid = 1'b1;
            load_err     = err_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_reg       <= '0;
            rd_we_reg    <= 1'b0;
            is_load_reg  <= 1'b0;
            funct3_reg   <= '0;
            addr_reg     <= '0;
            alu_res_reg  <= '0;
            load_res_reg <= '0;
            err_reg      <= 1'b0;
        end else if (accept) begin
            rd_reg       <= in_rd;
            rd_we_reg    <= in_rd_we;
            is_load_reg  <= in_is_load;
            funct3_reg   <= in_funct3;
            addr_reg     <= in_addr;
            alu_res_reg  <= in_alu_res;
            load_res_reg <= '0;
            err_reg      <= in_err;
        end else if (state_reg == MEM && dmem_ack) begin
            load_res_reg <= load_ext;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: inputs change on the falling edge, outputs
// are compared on the falling edge against hand-computed values.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic        in_rd_we = 1'b0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [63:0] in_addr = '0;
    logic [63:0] in_alu_res = '0;
    logic        dmem_req;
    logic [63:0] dmem_addr;
    logic        dmem_ack = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic [4:0]  WriteAddr;
    logic [63:0] WriteData;
    logic        WriteEnable;
    logic        retire_valid;
    logic        load_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_alu_res(in_alu_res),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteEnable(WriteEnable),
        .retire_valid(retire_valid), .load_err(load_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one instruction for a single cycle; returns in the cycle after the accept edge.
    task automatic issue(input string tag, input logic [4:0] rd, input logic we, input logic ld,
                         input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] alu);
        check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_rd_we   = we;
        in_is_load = ld;
        in_funct3  = f3;
        in_addr    = addr;
        in_alu_res = alu;
        @(negedge clk);
        in_valid   = 1'b0;
        in_addr    = 64'hDEAD_BEEF_DEAD_BEEF;
        in_alu_res = 64'hBAD0_BAD0_BAD0_BAD0;
        $display("txn %s rd=%0d ld=%0b f3=%0d addr=0x%0h alu=0x%0h", tag, rd, ld, f3, addr, alu);
    endtask

    task automatic expect_wb(input string tag, input logic [4:0] wa, input logic [63:0] wd,
                             input logic we, input logic err);
        check({tag, ".retire"}, {63'd0, retire_valid}, 64'd1);
        check({tag, ".we"}, {63'd0, WriteEnable}, {63'd0, we});
        check({tag, ".waddr"}, {59'd0, WriteAddr}, {59'd0, wa});
        check({tag, ".wdata"}, WriteData, wd);
        check({tag, ".load_err"}, {63'd0, load_err}, {63'd0, err});
        check({tag, ".req_wb"}, {63'd0, dmem_req}, 64'd0);
        check({tag, ".ready_wb"}, {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check({tag, ".idle_retire"}, {63'd0, retire_valid}, 64'd0);
        check({tag, ".idle_wdata"}, WriteData, 64'd0);
        $display("txn %s wb waddr=%0d wdata=0x%0h we=%0b err=%0b", tag, wa, wd, we, err);
    endtask

    // Load with an immediate or delayed ack; mem_cycles counts MEM cycles including the ack cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input int mem_cycles, input logic [63:0] wd);
        issue(tag, 5'd7, 1'b1, 1'b1, f3, addr, 64'h0);
        for (int i = 0; i < mem_cycles; i++) begin
            check({tag, ".req"}, {63'd0, dmem_req}, 64'd1);
            check({tag, ".daddr"}, dmem_addr, {addr[63:3], 3'b000});
            check({tag, ".ready_mem"}, {63'd0, in_ready}, 64'd0);
            check({tag, ".we_mem"}, {63'd0, WriteEnable}, 64'd0);
            if (i == mem_cycles - 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = 64'h0;
        end
        expect_wb(tag, 5'd7, wd, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst.ready", {63'd0, in_ready}, 64'd0);
        check("rst.req", {63'd0, dmem_req}, 64'd0);
        check("rst.we", {63'd0, WriteEnable}, 64'd0);
        check("rst.retire", {63'd0, retire_valid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Non-load, with a stray ack during WB that must be ignored
        issue("alu", 5'd5, 1'b1, 1'b0, 3'd0, 64'h0, 64'h1234);
        dmem_ack = 1'b1;
        dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        expect_wb("alu", 5'd5, 64'h1234, 1'b1, 1'b0);
        dmem_ack = 1'b0;
        check("alu.stray_ack_req", {63'd0, dmem_req}, 64'd0);

        do_load("lb",  3'b000, 64'h1003, 64'h0000_0000_8000_0000, 1, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lbu", 3'b100, 64'h1003, 64'h0000_0000_8000_0000, 1, 64'h0000_0000_0000_0080);
        do_load("lw",  3'b010, 64'h2004, 64'h8765_4321_0000_0000, 3, 64'hFFFF_FFFF_8765_4321);
        do_load("lwu", 3'b110, 64'h2004, 64'h8765_4321_0000_0000, 1, 64'h0000_0000_8765_4321);
        do_load("lh",  3'b001, 64'h1006, 64'h8001_0000_0000_0000, 2, 64'hFFFF_FFFF_FFFF_8001);
        do_load("lhu", 3'b101, 64'h1002, 64'h0000_0000_9ABC_0000, 1, 64'h0000_0000_0000_9ABC);
        do_load("ld",  3'b011, 64'h3008, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF);

        // rd = 0 non-load: retires without writing
        issue("rd0", 5'd0, 1'b1, 1'b0, 3'd0, 64'h0, 64'h55);
        expect_wb("rd0", 5'd0, 64'h55, 1'b0, 1'b0);

        // Misaligned and illegal loads skip memory
        issue("lh_mis", 5'd9, 1'b1, 1'b1, 3'b001, 64'h1001, 64'h0);
        expect_wb("lh_mis", 5'd9, 64'h0, 1'b0, 1'b1);
        issue("ld_mis", 5'd9, 1'b1, 1'b1, 3'b011, 64'h1004, 64'h0);
        expect_wb("ld_mis", 5'd9, 64'h0, 1'b0, 1'b1);
        issue("f3_111", 5'd9, 1'b1, 1'b1, 3'b111, 64'h1000, 64'h0);
        expect_wb("f3_111", 5'd9, 64'h0, 1'b0, 1'b1);

        // Reset during MEM discards the load
        issue("rst_mem", 5'd3, 1'b1, 1'b1, 3'b011, 64'h3000, 64'h0);
        check("rst_mem.req_before", {63'd0, dmem_req}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mem.req_async", {63'd0, dmem_req}, 64'd0);
        check("rst_mem.ready_async", {63'd0, in_ready}, 64'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_mem.no_we", {63'd0, WriteEnable}, 64'd0);
            check("rst_mem.no_retire", {63'd0, retire_valid}, 64'd0);
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        check("rst_mem.ready_after", {63'd0, in_ready}, 64'd1);

        issue("post_rst", 5'd12, 1'b1, 1'b0, 3'd0, 64'h0, 64'hCAFE);
        expect_wb("post_rst", 5'd12, 64'hCAFE, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
